// File: rtl/fetch_ctrl_pkg.sv
// Shared MIPS definitions for the fetch controller: instruction constants,
// controller state encoding and fault codes.
package fetch_ctrl_pkg;

    localparam logic [5:0] OpSpecial    = 6'h00;
    localparam logic [5:0] FunctSyscall = 6'h0C;

    typedef enum logic [2:0] {
        StIdle,
        StFetch,
        StExec,
        StHalt,
        StFault
    } fetch_state_e;

    typedef enum logic [1:0] {
        FaultNone       = 2'b00,
        FaultTimeout    = 2'b01,
        FaultMisaligned = 2'b10
    } fault_code_e;

    function automatic logic is_syscall(input logic [31:0] word);
        return (word[31:26] == OpSpecial) && (word[5:0] == FunctSyscall);
    endfunction

endpackage

// File: rtl/fetch_ctrl_next_pc_sel.sv
// Combinational next-PC target mux with word-alignment check.
// Jump has priority over a taken branch; otherwise fall through to pc + 4.
module fetch_ctrl_next_pc_sel (
    input  logic [31:0] pc,
    input  logic        jump,
    input  logic [31:0] jump_target,
    input  logic        branch_taken,
    input  logic [31:0] branch_target,
    output logic [31:0] target,
    output logic        misaligned
);

    always_comb begin
        if (jump) begin
            target = jump_target;
        end else if (branch_taken) begin
            target = branch_target;
        end else begin
            target = pc + 32'd4;
        end
    end

    assign misaligned = |target[1:0];

endmodule

// File: rtl/fetch_ctrl.sv
// PC / instruction-memory sequencer: fetch, execute one instruction, pick the
// next PC. Halts on SYSCALL and stops with a fault on timeout or bad target.
module fetch_ctrl
    import fetch_ctrl_pkg::*;
#(
    parameter int unsigned MAX_WAIT        = 16,
    parameter bit          HALT_ON_SYSCALL = 1'b1
) (
    input  logic        clock,
    input  logic        reset,
    input  logic [31:0] PC,
    output logic [31:0] nextPC,
    output logic        imem_req,
    output logic [31:0] imem_addr,
    input  logic        imem_ready,
    input  logic [31:0] imem_rdata,
    output logic [31:0] instr,
    output logic        instr_valid,
    input  logic        stall,
    input  logic        jump,
    input  logic [31:0] jump_target,
    input  logic        branch_taken,
    input  logic [31:0] branch_target,
    output logic        halted,
    output logic        fault,
    output logic [1:0]  fault_code
);

    localparam int unsigned     WaitW    = (MAX_WAIT > 1) ? $clog2(MAX_WAIT) : 1;
    localparam logic [WaitW-1:0] WaitLast = WaitW'(MAX_WAIT - 1);

    fetch_state_e     state_q, state_d;
    logic [WaitW-1:0] wait_cnt_q, wait_cnt_d;
    logic [31:0]      instr_q, instr_d;
    fault_code_e      fault_code_q, fault_code_d;

    logic [31:0] target;
    logic        misaligned;

    fetch_ctrl_next_pc_sel u_next_pc_sel (
        .pc            (PC),
        .jump          (jump),
        .jump_target   (jump_target),
        .branch_taken  (branch_taken),
        .branch_target (branch_target),
        .target        (target),
        .misaligned    (misaligned)
    );

    always_comb begin
        state_d      = state_q;
        wait_cnt_d   = wait_cnt_q;
        instr_d      = instr_q;
        fault_code_d = fault_code_q;
        nextPC       = PC;
        imem_req     = 1'b0;
        instr_valid  = 1'b0;

        case (state_q)
            StIdle: begin
                state_d    = StFetch;
                wait_cnt_d = '0;
            end
            StFetch: begin
                imem_req = 1'b1;
                if (imem_ready) begin
                    instr_d = imem_rdata;
                    state_d = StExec;
                end else if (wait_cnt_q == WaitLast) begin
                    state_d      = StFault;
                    fault_code_d = FaultTimeout;
                end else begin
                    wait_cnt_d = wait_cnt_q + WaitW'(1);
                end
            end
            StExec: begin
                instr_valid = 1'b1;
                if (!stall) begin
                    if (misaligned) begin
                        state_d      = StFault;
                        fault_code_d = FaultMisaligned;
                    end else begin
                        // SYSCALL still retires: the PC advances on the way into halt.
                        nextPC     = target;
                        wait_cnt_d = '0;
                        state_d    = (HALT_ON_SYSCALL && is_syscall(instr_q)) ? StHalt : StFetch;
                    end
                end
            end
            StHalt, StFault: begin
            end
            default: begin
                state_d = StIdle;
            end
        endcase
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state_q      <= StIdle;
            wait_cnt_q   <= '0;
            instr_q      <= '0;
            fault_code_q <= FaultNone;
        end else begin
            state_q      <= state_d;
            wait_cnt_q   <= wait_cnt_d;
            instr_q      <= instr_d;
            fault_code_q <= fault_code_d;
        end
    end

    assign imem_addr  = PC;
    assign instr      = instr_q;
    assign fault_code = fault_code_q;
    assign halted     = (state_q == StHalt);
    assign fault      = (state_q == StFault);

endmodule
